multicycle_control: RTL and testbench

Multi-cycle MIPS controller FSM that sequences the shared datapath (single memory, one ALU, IR, PC, register file) through fetch, decode, execute, memory and writeback steps. It supports R-type, lw, sw, beq, addi and j. A MemReady handshake on every memory access allows wait-stated memory. It replaces the single-cycle decoder when the processor is built in its multi-cycle configuration.

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 157 +++++++++++++++
 tb/tb_multicycle_control.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multi-cycle controller and the MIPS datapath.
// The controller drives the master side; the datapath (or a bench) uses the slave side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       retire;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire,
           illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, retire,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/writeback for
// R-type, lw, sw, beq, addi and j, stretching memory states until mem_ready.
module multicycle_control (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  multicycle_control_if.master bus_io
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StIllegal = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  state_q <= bus_io.mem_ready ? StDecode : StFetch;
        StDecode: begin
          case (bus_io.opcode)
            OpRType:    state_q <= StExec;
            OpLw, OpSw: state_q <= StMemAdr;
            OpBeq:      state_q <= StBranch;
            OpAddi:     state_q <= StAddiEx;
            OpJ:        state_q <= StJump;
            default:    state_q <= StIllegal;
          endcase
        end
        StMemAdr: state_q <= (bus_io.opcode == OpLw) ? StMemRd : StMemWr;
        StMemRd:  state_q <= bus_io.mem_ready ? StMemWb : StMemRd;
        StMemWr:  state_q <= bus_io.mem_ready ? StFetch : StMemWr;
        StExec:   state_q <= StAluWb;
        StAddiEx: state_q <= StAddiWb;
        // Writeback, branch, jump, illegal and unused codes all return to fetch.
        default:  state_q <= StFetch;
      endcase
    end
  end

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // Decoded from the current state only; reset forces every strobe low immediately.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    retire        = 1'b0;
    illegal_op    = 1'b0;
    if (rst_ni) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = bus_io.mem_ready;
          pc_write  = bus_io.mem_ready;
        end
        StDecode: alu_src_b = 2'b11;
        StMemAdr, StAddiEx: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRd: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        StMemWb: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          retire     = 1'b1;
        end
        StMemWr: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = bus_io.mem_ready;
        end
        StExec: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        StAluWb: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          retire        = 1'b1;
        end
        StJump: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          retire    = 1'b1;
        end
        StAddiWb: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        StIllegal: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_io.pc_write      = pc_write;
  assign bus_io.pc_write_cond = pc_write_cond;
  assign bus_io.iord          = iord;
  assign bus_io.mem_read      = mem_read;
  assign bus_io.mem_write     = mem_write;
  assign bus_io.ir_write      = ir_write;
  assign bus_io.mem_to_reg    = mem_to_reg;
  assign bus_io.reg_dst       = reg_dst;
  assign bus_io.reg_write     = reg_write;
  assign bus_io.alu_src_a     = alu_src_a;
  assign bus_io.alu_src_b     = alu_src_b;
  assign bus_io.alu_op        = alu_op;
  assign bus_io.pc_source     = pc_source;
  assign bus_io.retire        = retire;
  assign bus_io.illegal_op    = illegal_op;
  assign bus_io.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-vector checks
// against hand-computed expectations.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus.master)
  );

  always #5 clk = ~clk;

  // Packing order: pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb[2] aluop[2] pcsrc[2] ret ill
  localparam logic [17:0] E_ZERO = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_F1   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_F0   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] E_ADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_MRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_MWR1 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] E_MWR0 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_EXE  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] E_AWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] E_BR   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] E_JMP  = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] E_AIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  function automatic logic [17:0] outs();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.retire, bus.illegal_op};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'b000000;
    #2;
    vecs++;
    if (bus.state !== 4'd0 || outs() !== E_ZERO) begin
      errs++;
      $display("FAIL reset_hold: state=%0d outs=%b, expected state=0 outs=%b",
               bus.state, outs(), E_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++;
    if (bus.state !== 4'd0 || outs() !== E_F1) begin
      errs++;
      $display("FAIL reset_release: state=%0d outs=%b, expected state=0 outs=%b",
               bus.state, outs(), E_F1);
    end
    @(negedge clk);
    #1;
    vecs++;
    if (bus.state !== 4'd1 || outs() !== E_DEC) begin
      errs++;
      $display("FAIL reset_decode: state=%0d outs=%b, expected state=1 outs=%b",
               bus.state, outs(), E_DEC);
    end
    @(negedge clk);
    #1;
    vecs++;
    if (bus.state !== 4'd6 || outs() !== E_EXE) begin
      errs++;
      $display("FAIL reset_exec: state=%0d outs=%b, expected state=6 outs=%b",
               bus.state, outs(), E_EXE);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.state !== 4'd0 || outs() !== E_ZERO) begin
      errs++;
      $display("FAIL reset_abort: state=%0d outs=%b, expected state=0 outs=%b",
               bus.state, outs(), E_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++;
    if (bus.state !== 4'd0 || outs() !== E_F1) begin
      errs++;
      $display("FAIL reset_refetch: state=%0d outs=%b, expected state=0 outs=%b",
               bus.state, outs(), E_F1);
    end
    bus.mem_ready = 1'b0;  // park in FETCH until the next test starts
    @(negedge clk);
  endtask

  // lw with no wait states, then lw with one MEMRD wait state.
  task automatic test_lw();
    bit          rdy [11] = '{1, 0, 0, 1, 0, 1, 1, 1, 0, 1, 0};
    logic [3:0]  st  [11] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 3, 4};
    logic [17:0] ex  [11] = '{E_F1, E_DEC, E_ADR, E_MRD, E_MWB,
                              E_F1, E_DEC, E_ADR, E_MRD, E_MRD, E_MWB};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 11; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      vecs++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        errs++;
        $display("FAIL lw cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_wait();
    bit          rdy [6] = '{1, 0, 0, 0, 0, 1};
    logic [3:0]  st  [6] = '{0, 1, 2, 5, 5, 5};
    logic [17:0] ex  [6] = '{E_F1, E_DEC, E_ADR, E_MWR0, E_MWR0, E_MWR1};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      vecs++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        errs++;
        $display("FAIL sw_wait cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_wait();
    bit          rdy [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic [3:0]  st  [7] = '{0, 0, 0, 0, 1, 9, 0};
    logic [17:0] ex  [7] = '{E_F0, E_F0, E_F0, E_F1, E_DEC, E_JMP, E_F1};
    bus.opcode = 6'b000010;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      vecs++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        errs++;
        $display("FAIL fetch_wait cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      @(negedge clk);
    end
  endtask

  // Starts in DECODE (previous test left a fetch completing): re-sync via a j first.
  task automatic test_back_to_back();
    logic [5:0]  op [16] = '{6'o02, 6'o02,
                             6'o00, 6'o00, 6'o00, 6'o00,
                             6'o04, 6'o04, 6'o04,
                             6'o02, 6'o02, 6'o02,
                             6'o10, 6'o10, 6'o10, 6'o10};
    logic [3:0]  st [16] = '{1, 9, 0, 1, 6, 7, 0, 1, 8, 0, 1, 9, 0, 1, 10, 11};
    logic [17:0] ex [16] = '{E_DEC, E_JMP,
                             E_F1, E_DEC, E_EXE, E_AWB,
                             E_F1, E_DEC, E_BR,
                             E_F1, E_DEC, E_JMP,
                             E_F1, E_DEC, E_ADR, E_AIWB};
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.opcode = op[i];
      #1;
      vecs++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        errs++;
        $display("FAIL back_to_back cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [5:0]  op  [7] = '{6'b111111, 6'b111111, 6'b111111,
                             6'b000011, 6'b000011, 6'b000011, 6'b000011};
    bit          rdy [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [3:0]  st  [7] = '{0, 1, 12, 0, 1, 12, 0};
    logic [17:0] ex  [7] = '{E_F1, E_DEC, E_ILL, E_F1, E_DEC, E_ILL, E_F0};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = op[i];
      bus.mem_ready = rdy[i];
      #1;
      vecs++;
      if (bus.state !== st[i] || outs() !== ex[i]) begin
        errs++;
        $display("FAIL illegal cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 i, bus.state, outs(), st[i], ex[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_fetch_wait();
    test_back_to_back();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
